// File: rtl/spis_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spis_pkg
// Description : Shared opcodes, FSM states and phase lengths for the SPI
//               slave register bridge.
// Revision    : 1.0 - initial release
// ============================================================================
package spis_pkg;

    // Default opcodes of the register-access protocol
    localparam logic [7:0] SPIS_CMD_WR = 8'h2F;
    localparam logic [7:0] SPIS_CMD_RD = 8'h10;

    // Phase lengths in SPI bits
    localparam int unsigned CMD_BITS   = 8;
    localparam int unsigned ADDR_BITS  = 32;
    localparam int unsigned DATA_BITS  = 32;
    localparam int unsigned DUMMY_BITS = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CMD    = 3'd1,
        ST_ADDR   = 3'd2,
        ST_WDATA  = 3'd3,
        ST_DUMMY  = 3'd4,
        ST_RDATA  = 3'd5,
        ST_IGNORE = 3'd6
    } spis_state_e;

    // Bit-counter value reached on the last bit of a phase
    function automatic logic [5:0] phase_last(input spis_state_e st);
        case (st)
            ST_CMD:   phase_last = 6'(CMD_BITS - 1);
            ST_ADDR:  phase_last = 6'(ADDR_BITS - 1);
            ST_WDATA: phase_last = 6'(DATA_BITS - 1);
            ST_DUMMY: phase_last = 6'(DUMMY_BITS - 1);
            ST_RDATA: phase_last = 6'(DATA_BITS - 1);
            default:  phase_last = 6'd0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/spis_sync_edge.sv
`default_nettype none
// ============================================================================
// Module      : spis_sync_edge
// Description : N-stage synchronizer for an asynchronous pin with rise/fall
//               pulses derived from the last two stages.
// Revision    : 1.0 - initial release
// ============================================================================
module spis_sync_edge #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] r_sync;

    // Shift the pin through the synchronizer chain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= {STAGES{RST_VAL}};
        end else begin
            r_sync <= {r_sync[STAGES-2:0], async_in};
        end
    end

    // Newer stage differs from the oldest stage -> single-cycle edge pulse
    assign rise =  r_sync[STAGES-2] & ~r_sync[STAGES-1];
    assign fall = ~r_sync[STAGES-2] &  r_sync[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/spis_reg_bridge.sv
`default_nettype none
// ============================================================================
// Module      : spis_reg_bridge
// Description : Oversampled SPI slave that turns each write/read frame into
//               one 32-bit register-bus cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module spis_reg_bridge
    import spis_pkg::*;
#(
    parameter int          SYNC_STAGES = 2,
    parameter logic [7:0]  CMD_WR      = spis_pkg::SPIS_CMD_WR,
    parameter logic [7:0]  CMD_RD      = spis_pkg::SPIS_CMD_RD,
    parameter logic [31:0] ERR_DATA    = 32'hDEAD_BEEF
) (
    input  logic        mclk,
    input  logic        reset_n,
    input  logic        spi_clk,
    input  logic        spi_sel_n,
    input  logic        spi_din,
    output logic        spi_dout,
    output logic        spi_dout_en,
    output logic        reg_cs,
    output logic        reg_wr,
    output logic [31:0] reg_addr,
    output logic [31:0] reg_wdata,
    output logic [3:0]  reg_be,
    input  logic [31:0] reg_rdata,
    input  logic        reg_ack
);

    // ------------------------------------------------------------------
    // Pin synchronization
    // ------------------------------------------------------------------
    logic w_sclk_rise, w_sclk_fall, w_sel_rise, w_sel_fall;
    logic [SYNC_STAGES-1:0] r_din_sync;
    logic w_din;

    spis_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
        .clk      (mclk),
        .rst_n    (reset_n),
        .async_in (spi_clk),
        .rise     (w_sclk_rise),
        .fall     (w_sclk_fall)
    );

    // Select resets to the deselected level so reset release is not a frame start
    spis_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_sel (
        .clk      (mclk),
        .rst_n    (reset_n),
        .async_in (spi_sel_n),
        .rise     (w_sel_rise),
        .fall     (w_sel_fall)
    );

    // Data pin only needs the synchronizer, no edge detect
    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) begin
            r_din_sync <= '0;
        end else begin
            r_din_sync <= {r_din_sync[SYNC_STAGES-2:0], spi_din};
        end
    end
    assign w_din = r_din_sync[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Frame parser state
    // ------------------------------------------------------------------
    spis_state_e r_state;
    logic [5:0]  r_bit_cnt;
    logic [31:0] r_shift;
    logic        r_is_rd;
    logic [31:0] r_frame_addr;
    logic [31:0] r_rd_shift;
    logic        r_rd_got;

    // Bus-side state
    logic        r_pend;
    logic        r_pend_wr;
    logic        r_pend_cur;
    logic [31:0] r_pend_addr;
    logic [31:0] r_pend_wdata;
    logic        r_bus_cur;

    logic [31:0] w_sampled;
    logic        w_last;
    logic        w_addr_done;
    logic        w_wdata_done;
    logic        w_rd_req;
    logic        w_wr_req;
    logic        w_req;
    logic [31:0] w_req_addr;
    logic        w_enter_rdata;
    logic        w_frame_end;
    logic        w_drop_cur;
    logic        w_cap;
    logic [31:0] w_rd_load;

    assign w_sampled     = {r_shift[30:0], w_din};
    assign w_last        = (r_bit_cnt == phase_last(r_state));
    assign w_addr_done   = (r_state == ST_ADDR)  && w_sclk_rise && w_last && !w_sel_rise;
    assign w_wdata_done  = (r_state == ST_WDATA) && w_sclk_rise && w_last && !w_sel_rise;
    assign w_rd_req      = w_addr_done && r_is_rd;
    assign w_wr_req      = w_wdata_done;
    assign w_req         = w_rd_req || w_wr_req;
    assign w_req_addr    = w_wr_req ? r_frame_addr : w_sampled;
    assign w_enter_rdata = (r_state == ST_DUMMY) && w_sclk_rise && w_last && !w_sel_rise && r_is_rd;
    assign w_frame_end   = (r_state != ST_IDLE) && w_sel_rise;
    // Once the read phase starts (or the frame dies) a later ack is stale
    assign w_drop_cur    = w_enter_rdata || w_frame_end;
    // Read data belongs to this frame only while the frame still awaits it
    assign w_cap         = reg_cs && reg_ack && !reg_wr && r_bus_cur;
    assign w_rd_load     = w_cap ? reg_rdata : (r_rd_got ? r_rd_shift : ERR_DATA);

    // Frame FSM: bit counting, shifting, and registered SPI output
    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_bit_cnt    <= 6'd0;
            r_shift      <= 32'd0;
            r_is_rd      <= 1'b0;
            r_frame_addr <= 32'd0;
            r_rd_shift   <= 32'd0;
            r_rd_got     <= 1'b0;
            spi_dout     <= 1'b0;
            spi_dout_en  <= 1'b0;
        end else begin
            if (w_cap) begin
                r_rd_shift <= reg_rdata;
                r_rd_got   <= 1'b1;
            end
            if (r_state == ST_IDLE) begin
                spi_dout    <= 1'b0;
                spi_dout_en <= 1'b0;
                if (w_sel_fall) begin
                    r_state   <= ST_CMD;
                    r_bit_cnt <= 6'd0;
                end
            end else if (w_sel_rise) begin
                r_state     <= ST_IDLE;
                r_bit_cnt   <= 6'd0;
                spi_dout    <= 1'b0;
                spi_dout_en <= 1'b0;
            end else begin
                case (r_state)
                    ST_CMD, ST_ADDR, ST_WDATA, ST_DUMMY: begin
                        if (w_sclk_rise) begin
                            r_shift <= w_sampled;
                            if (!w_last) begin
                                r_bit_cnt <= r_bit_cnt + 6'd1;
                            end else begin
                                r_bit_cnt <= 6'd0;
                                case (r_state)
                                    ST_CMD: begin
                                        if (w_sampled[7:0] == CMD_WR || w_sampled[7:0] == CMD_RD) begin
                                            r_state <= ST_ADDR;
                                            r_is_rd <= (w_sampled[7:0] == CMD_RD);
                                        end else begin
                                            r_state <= ST_IGNORE;
                                        end
                                    end
                                    ST_ADDR: begin
                                        r_frame_addr <= w_sampled;
                                        if (r_is_rd) begin
                                            r_state  <= ST_DUMMY;
                                            r_rd_got <= 1'b0;
                                        end else begin
                                            r_state  <= ST_WDATA;
                                        end
                                    end
                                    ST_WDATA: r_state <= ST_DUMMY;
                                    default: begin
                                        if (r_is_rd) begin
                                            r_state     <= ST_RDATA;
                                            r_rd_shift  <= w_rd_load;
                                            spi_dout    <= w_rd_load[31];
                                            spi_dout_en <= 1'b1;
                                        end else begin
                                            r_state <= ST_IGNORE;
                                        end
                                    end
                                endcase
                            end
                        end
                    end
                    ST_RDATA: begin
                        // Counter counts master sample edges; the falling edge
                        // that follows the last dummy bit must not advance,
                        // otherwise bit31 would never be sampled.
                        if (w_sclk_rise) begin
                            if (w_last) begin
                                r_state     <= ST_IGNORE;
                                r_bit_cnt   <= 6'd0;
                                spi_dout    <= 1'b0;
                                spi_dout_en <= 1'b0;
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 6'd1;
                            end
                        end else if (w_sclk_fall && r_bit_cnt != 6'd0) begin
                            r_rd_shift <= {r_rd_shift[30:0], 1'b0};
                            spi_dout   <= r_rd_shift[30];
                        end
                    end
                    default: begin
                        // IGNORE: wait for deselect
                    end
                endcase
            end
        end
    end

    // Bus master: issue requests, queue one behind an outstanding cycle
    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) begin
            reg_cs       <= 1'b0;
            reg_wr       <= 1'b0;
            reg_addr     <= 32'd0;
            reg_wdata    <= 32'd0;
            r_pend       <= 1'b0;
            r_pend_wr    <= 1'b0;
            r_pend_cur   <= 1'b0;
            r_pend_addr  <= 32'd0;
            r_pend_wdata <= 32'd0;
            r_bus_cur    <= 1'b0;
        end else begin
            if (reg_cs && reg_ack) begin
                reg_cs    <= 1'b0;
                r_bus_cur <= 1'b0;
            end
            if (w_drop_cur) begin
                r_bus_cur  <= 1'b0;
                r_pend_cur <= 1'b0;
            end
            if (w_req) begin
                if (!reg_cs && !r_pend) begin
                    reg_cs    <= 1'b1;
                    reg_wr    <= w_wr_req;
                    reg_addr  <= w_req_addr;
                    if (w_wr_req) begin
                        reg_wdata <= w_sampled;
                    end
                    r_bus_cur <= w_rd_req;
                end else begin
                    r_pend       <= 1'b1;
                    r_pend_wr    <= w_wr_req;
                    r_pend_addr  <= w_req_addr;
                    r_pend_wdata <= w_sampled;
                    r_pend_cur   <= w_rd_req;
                end
            end else if (r_pend && !reg_cs) begin
                reg_cs    <= 1'b1;
                reg_wr    <= r_pend_wr;
                reg_addr  <= r_pend_addr;
                if (r_pend_wr) begin
                    reg_wdata <= r_pend_wdata;
                end
                r_bus_cur <= r_pend_cur;
                r_pend    <= 1'b0;
            end
        end
    end

    assign reg_be = 4'hF;

endmodule
`default_nettype wire
